// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NREQ
// valid/ready requesters in the wclk domain, in bursts of up to MAX_BURST.
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DSIZE     = 8,
    parameter int MAX_BURST = 4,
    parameter int CNTW      = 16
) (
    input  logic                      wclk,
    input  logic                      wrst,
    input  logic                      arb_en,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*DSIZE-1:0]     req_data,
    output logic [NREQ-1:0]           req_ready,
    input  logic                      wfull,
    output logic                      winc,
    output logic [DSIZE-1:0]          wdata,
    output logic [$clog2(NREQ)-1:0]   gnt_id,
    output logic                      busy,
    output logic [CNTW-1:0]           wr_count
);

    localparam int IDW = $clog2(NREQ);
    localparam int BW  = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   gnt_q, gnt_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;

    logic             found;
    logic [IDW-1:0]   pick;
    logic [IDW-1:0]   cand;
    logic [DSIZE-1:0] sel_data;
    logic             vld_g;
    logic             fire;

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_q <= IDLE;
            gnt_q   <= IDW'(NREQ - 1);
            beat_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
        end
    end

    // Search starts just after the last grant so every requester gets a turn.
    always_comb begin
        found = 1'b0;
        pick  = gnt_q;
        cand  = gnt_q;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(gnt_q) + k) % NREQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_q == IDW'(i)) begin
                sel_data = req_data[i*DSIZE +: DSIZE];
            end
        end
    end

    assign vld_g = req_valid[gnt_q];
    assign fire  = (state_q == GRANT) & vld_g & ~wfull & ~wrst;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (arb_en && found) begin
                    gnt_d   = pick;
                    beat_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!vld_g) begin
                    state_d = IDLE;
                end else if (fire) begin
                    cnt_d = cnt_q + CNTW'(1);
                    if (beat_q == BW'(MAX_BURST - 1)) begin
                        beat_d  = '0;
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
        endcase
    end

    assign winc      = fire;
    assign wdata     = fire ? sel_data : '0;
    assign req_ready = fire ? (NREQ'(1) << gnt_q) : '0;
    assign gnt_id    = gnt_q;
    assign busy      = (state_q == GRANT) & ~wrst;
    assign wr_count  = cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: queue-driven requesters, burst-level
// round-robin model, per-cycle write and handshake checks.
module tb_fifo_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int DSIZE = 8;
    localparam int MB    = 4;
    localparam int CNTW  = 8;

    logic                  wclk = 1'b0;
    logic                  wrst = 1'b1;
    logic                  arb_en = 1'b1;
    logic                  wfull = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*DSIZE-1:0] req_data = '0;
    logic [NREQ-1:0]       req_ready;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
    logic [1:0]            gnt_id;
    logic                  busy;
    logic [CNTW-1:0]       wr_count;

    fifo_wr_arbiter #(
        .NREQ(NREQ), .DSIZE(DSIZE), .MAX_BURST(MB), .CNTW(CNTW)
    ) dut (
        .wclk(wclk), .wrst(wrst), .arb_en(arb_en),
        .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .wfull(wfull), .winc(winc),
        .wdata(wdata), .gnt_id(gnt_id), .busy(busy),
        .wr_count(wr_count)
    );

    always #5 wclk = ~wclk;

    int n_tests = 0;
    int n_fail = 0;
    logic [DSIZE-1:0] q [NREQ][$];
    int breq[$], blen[$], bgap[$];
    int ereq[$], elen[$];
    int cnt [NREQ];
    int seen = 0;
    int exp_words = 0;
    int model_last = NREQ - 1;
    bit mon_busy = 0;
    bit rand_full = 0;
    int cur_req = 0, cur_len = 0, idle = 0;

    // Requesters present their queue heads; words leave only on acceptance.
    always @(posedge wclk) begin
        #1;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = q[i].size() > 0;
            req_data[i*DSIZE +: DSIZE] = (q[i].size() > 0) ? q[i][0] : '0;
        end
        if (rand_full) wfull = ($urandom_range(0, 9) < 3);
    end

    always @(negedge wclk) begin
        if (wrst) begin
            mon_busy = 0; idle = 0; cur_len = 0;
        end else begin
            n_tests++;
            if ((winc && wfull) || !$onehot0(req_ready) ||
                (winc != |req_ready) || (!winc && wdata != '0)) begin
                n_fail++;
                $display("FAIL invariant: winc=%0b wfull=%0b ready=%b wdata=%0h",
                         winc, wfull, req_ready, wdata);
            end
            if (busy && !mon_busy) begin
                cur_req = int'(gnt_id); cur_len = 0;
                bgap.push_back(idle); idle = 0;
            end
            if (!busy) idle++;
            if (winc) begin
                n_tests++;
                if (!busy || req_ready !== (NREQ'(1) << cur_req) ||
                    q[cur_req].size() == 0 || wdata !== q[cur_req][0]) begin
                    n_fail++;
                    $display("FAIL write: req=%0d ready=%b wdata=%0h busy=%0b",
                             cur_req, req_ready, wdata, busy);
                end
                if (q[cur_req].size() > 0) void'(q[cur_req].pop_front());
                cur_len++; seen++;
            end
            if (!busy && mon_busy) begin
                breq.push_back(cur_req); blen.push_back(cur_len);
            end
            mon_busy = busy;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic load(input int r, input int n);
        repeat (n) q[r].push_back(DSIZE'($urandom));
        exp_words += n;
    endtask

    task automatic clear_logs();
        breq.delete(); blen.delete(); bgap.delete();
        ereq.delete(); elen.delete();
    endtask

    // Burst-level model: rotate through non-empty requesters, each
    // taking min(MB, remaining) words per grant.
    task automatic model();
        int c [NREQ];
        bit f;
        int idx, len;
        c = cnt;
        forever begin
            f = 0; idx = 0;
            for (int k = 1; k <= NREQ; k++) begin
                if (!f && c[(model_last + k) % NREQ] > 0) begin
                    f = 1; idx = (model_last + k) % NREQ;
                end
            end
            if (!f) break;
            len = (c[idx] < MB) ? c[idx] : MB;
            c[idx] -= len;
            ereq.push_back(idx); elen.push_back(len);
            model_last = idx;
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < NREQ; i++) if (q[i].size() != 0) return 0;
        return 1;
    endfunction

    task automatic drain(input int lim, output bit ok);
        ok = 0;
        for (int c = 0; c < lim && !ok; c++) begin
            @(posedge wclk); #2;
            if (all_empty() && !mon_busy) ok = 1;
        end
    endtask

    task automatic wait_seen(input int target, output bit ok);
        ok = 0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(posedge wclk); #2;
            if (seen >= target) ok = 1;
        end
    endtask

    task automatic test_reset();
        bit ok;
        for (int i = 0; i < NREQ; i++) load(i, 1);
        repeat (3) begin
            @(posedge wclk);
            @(negedge wclk);
            n_tests++;
            if ({winc, req_ready, busy, wr_count, gnt_id} !==
                {1'b0, 4'b0, 1'b0, 8'd0, 2'd3}) begin
                n_fail++;
                $display("FAIL reset_outputs: winc=%0b ready=%b busy=%0b cnt=%0d gnt=%0d want 0/0/0/0/3",
                         winc, req_ready, busy, wr_count, gnt_id);
            end
        end
        @(posedge wclk); #1 wrst = 0;
        cnt = '{1, 1, 1, 1};
        model();
        drain(200, ok);
        n_tests++;
        if (!ok || breq.size() != ereq.size()) begin
            n_fail++;
            $display("FAIL reset_bursts: ok=%0b got=%0d want=%0d", ok, breq.size(), ereq.size());
        end else for (int i = 0; i < ereq.size(); i++) begin
            n_tests++;
            if (breq[i] !== ereq[i] || blen[i] !== elen[i]) begin
                n_fail++;
                $display("FAIL reset_burst%0d: req=%0d len=%0d want req=%0d len=%0d",
                         i, breq[i], blen[i], ereq[i], elen[i]);
            end
        end
        n_tests++;
        if (wr_count !== CNTW'(exp_words)) begin
            n_fail++;
            $display("FAIL reset_count: got=%0d want=%0d", wr_count, CNTW'(exp_words));
        end
    endtask

    task automatic test_single();
        bit ok;
        clear_logs();
        load(2, 10);
        cnt = '{0, 0, 10, 0};
        model();
        drain(300, ok);
        n_tests++;
        if (!ok || breq.size() != ereq.size()) begin
            n_fail++;
            $display("FAIL single_bursts: ok=%0b got=%0d want=%0d", ok, breq.size(), ereq.size());
        end else for (int i = 0; i < ereq.size(); i++) begin
            n_tests++;
            if (breq[i] !== ereq[i] || blen[i] !== elen[i] || (i > 0 && bgap[i] != 1)) begin
                n_fail++;
                $display("FAIL single_burst%0d: req=%0d len=%0d gap=%0d want req=%0d len=%0d gap=1",
                         i, breq[i], blen[i], bgap[i], ereq[i], elen[i]);
            end
        end
        n_tests++;
        if (wr_count !== CNTW'(exp_words)) begin
            n_fail++;
            $display("FAIL single_count: got=%0d want=%0d", wr_count, CNTW'(exp_words));
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        clear_logs();
        for (int i = 0; i < NREQ; i++) load(i, 8);
        cnt = '{8, 8, 8, 8};
        model();
        drain(500, ok);
        n_tests++;
        if (!ok || breq.size() != ereq.size()) begin
            n_fail++;
            $display("FAIL rr_bursts: ok=%0b got=%0d want=%0d", ok, breq.size(), ereq.size());
        end else for (int i = 0; i < ereq.size(); i++) begin
            n_tests++;
            if (breq[i] !== ereq[i] || blen[i] !== elen[i]) begin
                n_fail++;
                $display("FAIL rr_burst%0d: req=%0d len=%0d want req=%0d len=%0d",
                         i, breq[i], blen[i], ereq[i], elen[i]);
            end
        end
        n_tests++;
        if (wr_count !== CNTW'(exp_words)) begin
            n_fail++;
            $display("FAIL rr_count: got=%0d want=%0d", wr_count, CNTW'(exp_words));
        end
    endtask

    task automatic test_full_stall();
        bit ok;
        clear_logs();
        load(2, 8);
        cnt = '{0, 0, 8, 0};
        model();
        wait_seen(seen + 2, ok);
        wfull = 1;
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL stall_start: timeout want 2 words"); end
        repeat (5) begin
            @(negedge wclk);
            n_tests++;
            if (winc !== 1'b0 || busy !== 1'b1 || req_ready !== '0) begin
                n_fail++;
                $display("FAIL stall_hold: winc=%0b busy=%0b ready=%b want 0/1/0", winc, busy, req_ready);
            end
        end
        @(posedge wclk); #1 wfull = 0;
        drain(300, ok);
        n_tests++;
        if (!ok || breq.size() != ereq.size()) begin
            n_fail++;
            $display("FAIL stall_bursts: ok=%0b got=%0d want=%0d", ok, breq.size(), ereq.size());
        end else for (int i = 0; i < ereq.size(); i++) begin
            n_tests++;
            if (breq[i] !== ereq[i] || blen[i] !== elen[i]) begin
                n_fail++;
                $display("FAIL stall_burst%0d: req=%0d len=%0d want req=%0d len=%0d",
                         i, breq[i], blen[i], ereq[i], elen[i]);
            end
        end
    endtask

    task automatic test_early_arb();
        bit ok;
        clear_logs();
        load(1, 1); load(2, 3);
        cnt = '{0, 1, 3, 0};
        model();
        drain(300, ok);
        n_tests++;
        if (!ok || breq.size() != ereq.size()) begin
            n_fail++;
            $display("FAIL early_bursts: ok=%0b got=%0d want=%0d", ok, breq.size(), ereq.size());
        end else for (int i = 0; i < ereq.size(); i++) begin
            n_tests++;
            if (breq[i] !== ereq[i] || blen[i] !== elen[i] || (i > 0 && bgap[i] != 1)) begin
                n_fail++;
                $display("FAIL early_burst%0d: req=%0d len=%0d gap=%0d want req=%0d len=%0d gap=1",
                         i, breq[i], blen[i], bgap[i], ereq[i], elen[i]);
            end
        end
        clear_logs();
        load(0, 8);
        cnt = '{8, 0, 0, 0};
        model();
        wait_seen(seen + 1, ok);
        arb_en = 0;
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL arb_start: timeout want 1 word"); end
        ok = 0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(posedge wclk); #2;
            if (!mon_busy) ok = 1;
        end
        repeat (5) begin
            @(negedge wclk);
            n_tests++;
            if (busy !== 1'b0 || winc !== 1'b0) begin
                n_fail++;
                $display("FAIL arb_hold: busy=%0b winc=%0b want 0/0", busy, winc);
            end
        end
        n_tests++;
        if (!ok || blen.size() != 1 || blen[0] != MB || q[0].size() != 4) begin
            n_fail++;
            $display("FAIL arb_first_burst: ok=%0b bursts=%0d left=%0d want 1 burst of %0d, 4 left",
                     ok, blen.size(), q[0].size(), MB);
        end
        @(posedge wclk); #1 arb_en = 1;
        drain(300, ok);
        n_tests++;
        if (!ok || breq.size() != ereq.size()) begin
            n_fail++;
            $display("FAIL arb_bursts: ok=%0b got=%0d want=%0d", ok, breq.size(), ereq.size());
        end else for (int i = 0; i < ereq.size(); i++) begin
            n_tests++;
            if (breq[i] !== ereq[i] || blen[i] !== elen[i]) begin
                n_fail++;
                $display("FAIL arb_burst%0d: req=%0d len=%0d want req=%0d len=%0d",
                         i, breq[i], blen[i], ereq[i], elen[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        clear_logs();
        load(3, 8);
        wait_seen(seen + 2, ok);
        wrst = 1;
        for (int i = 0; i < NREQ; i++) q[i].delete();
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL midrst_start: timeout want 2 words"); end
        @(negedge wclk);
        n_tests++;
        if (winc !== 1'b0 || busy !== 1'b0 || req_ready !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: winc=%0b busy=%0b ready=%b want 0/0/0", winc, busy, req_ready);
        end
        @(posedge wclk); #1 wrst = 0;
        @(negedge wclk);
        n_tests++;
        if (wr_count !== '0 || busy !== 1'b0 || gnt_id !== 2'd3) begin
            n_fail++;
            $display("FAIL midrst_state: cnt=%0d busy=%0b gnt=%0d want 0/0/3", wr_count, busy, gnt_id);
        end
        exp_words = 0;
        model_last = NREQ - 1;
        clear_logs();
        for (int i = 0; i < NREQ; i++) load(i, 1);
        cnt = '{1, 1, 1, 1};
        model();
        drain(200, ok);
        n_tests++;
        if (!ok || breq.size() == 0 || breq[0] != 0 || wr_count !== CNTW'(exp_words)) begin
            n_fail++;
            $display("FAIL midrst_next: ok=%0b bursts=%0d cnt=%0d want first req 0, cnt %0d",
                     ok, breq.size(), wr_count, exp_words);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        clear_logs();
        for (int i = 0; i < NREQ; i++) load(i, 65);
        cnt = '{65, 65, 65, 65};
        model();
        drain(2000, ok);
        n_tests++;
        if (!ok || breq.size() != ereq.size()) begin
            n_fail++;
            $display("FAIL wrap_bursts: ok=%0b got=%0d want=%0d", ok, breq.size(), ereq.size());
        end
        n_tests++;
        if (wr_count !== CNTW'(exp_words % (1 << CNTW))) begin
            n_fail++;
            $display("FAIL wrap_count: got=%0d want=%0d", wr_count, exp_words % (1 << CNTW));
        end
    endtask

    task automatic test_random();
        bit ok;
        int n;
        rand_full = 1;
        for (int r = 0; r < 4; r++) begin
            clear_logs();
            for (int i = 0; i < NREQ; i++) begin
                n = $urandom_range(0, 9);
                cnt[i] = n;
                load(i, n);
            end
            model();
            drain(3000, ok);
            n_tests++;
            if (!ok || breq.size() != ereq.size()) begin
                n_fail++;
                $display("FAIL rand%0d_bursts: ok=%0b got=%0d want=%0d", r, ok, breq.size(), ereq.size());
            end else for (int i = 0; i < ereq.size(); i++) begin
                n_tests++;
                if (breq[i] !== ereq[i] || blen[i] !== elen[i]) begin
                    n_fail++;
                    $display("FAIL rand%0d_burst%0d: req=%0d len=%0d want req=%0d len=%0d",
                             r, i, breq[i], blen[i], ereq[i], elen[i]);
                end
            end
            n_tests++;
            if (wr_count !== CNTW'(exp_words)) begin
                n_fail++;
                $display("FAIL rand%0d_count: got=%0d want=%0d", r, wr_count, CNTW'(exp_words));
            end
        end
        rand_full = 0;
        @(posedge wclk); #2 wfull = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_full_stall();
        test_early_arb();
        test_mid_reset();
        test_wrap();
        test_random();
        repeat (2) @(posedge wclk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
